// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampling UART receiver with majority-vote bit sampling,
// configurable word format, sticky error flags and a show-ahead word FIFO.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               rx,
  input  logic                               rd_en,
  input  logic                               err_clr,
  output logic [DATA_BITS-1:0]               rd_data,
  output logic                               rd_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               busy,
  output logic                               frame_err,
  output logic                               parity_err,
  output logic                               overrun_err
);

  localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DW  = $clog2(DIV + 1);
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [SW-1:0] S_V0       = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1       = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2       = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST   = 4'(DATA_BITS - 1);
  localparam logic [1:0]    STOP_LAST  = 2'(STOP_BITS - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;

  // Front end: synchroniser, edge history and post-reset arming.
  logic       sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic       armed_q, armed_d;
  logic [1:0] settle_q, settle_d;
  logic       rxs, start_edge;

  // Receiver state.
  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [SW-1:0]          samp_q, samp_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [1:0]             stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   v0_q, v0_d, v1_q, v1_d;
  logic                   par_bad_q, par_bad_d;
  logic                   commit_q, commit_d;
  logic                   tick, in_bit, vote_now, bit_end, vote, par_ok;
  logic                   frame_evt, par_evt, ovr_evt;

  // FIFO and sticky flags.
  logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   do_push, do_pop;
  logic                   frame_err_q, frame_err_d, parity_err_q, parity_err_d;
  logic                   overrun_err_q, overrun_err_d;

  assign rxs      = sync2_q;
  assign tick     = (div_q == DIV_LAST);
  assign in_bit   = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PAR)   || (state_q == S_STOP);
  assign vote_now = in_bit && tick && (samp_q == S_V2);
  assign bit_end  = in_bit && tick && (samp_q == S_LAST);
  assign vote     = (v0_q & v1_q) | (v0_q & rxs) | (v1_q & rxs);
  assign par_ok   = (PARITY == 1) ? (^shift_q ^ vote) : ~(^shift_q ^ vote);

  // A start edge only counts once the synchroniser holds real samples and the
  // line has been seen idle, so a low line at reset release is ignored.
  assign start_edge = armed_q && prev_q && !rxs;

  // Front-end next state: shift rx through the synchroniser and arm after settling.
  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    prev_d   = rxs;
    settle_d = {settle_q[0], 1'b1};
    armed_d  = armed_q | (settle_q[1] & rxs);
  end

  // Front-end registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  // Receiver next-state: tick divider, sample counter, voting and frame sequencing.
  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + DW'(1);
    samp_d     = samp_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    par_bad_d  = par_bad_q;
    commit_d   = 1'b0;
    frame_evt  = 1'b0;
    par_evt    = 1'b0;

    if (in_bit && tick) begin
      samp_d = (samp_q == S_LAST) ? '0 : samp_q + SW'(1);
      if (samp_q == S_V0) v0_d = rxs;
      if (samp_q == S_V1) v1_d = rxs;
    end

    case (state_q)
      S_IDLE: begin
        samp_d = '0;
        if (start_edge) begin
          state_d = S_START;
          div_d   = '0;
        end
      end
      S_START: begin
        if (vote_now && vote) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
        end
      end
      S_DATA: begin
        if (vote_now) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d    = (PARITY != 0) ? S_PAR : S_STOP;
            stop_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (vote_now && !par_ok) begin
          par_bad_d = 1'b1;
          par_evt   = 1'b1;
        end
        if (bit_end) begin
          state_d    = S_STOP;
          stop_cnt_d = '0;
        end
      end
      S_STOP: begin
        if (vote_now) begin
          if (!vote) begin
            frame_evt = 1'b1;
            state_d   = S_BRK;
            samp_d    = '0;
          end else if (stop_cnt_q == STOP_LAST) begin
            state_d  = S_IDLE;
            commit_d = ~par_bad_q;
          end
        end else if (bit_end) begin
          stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      S_BRK: begin
        if (!rxs) begin
          samp_d = '0;
        end else if (tick) begin
          if (samp_q == S_LAST) state_d = S_IDLE;
          else                  samp_d  = samp_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      samp_q     <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      v0_q       <= 1'b1;
      v1_q       <= 1'b1;
      par_bad_q  <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      samp_q     <= samp_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      par_bad_q  <= par_bad_d;
      commit_q   <= commit_d;
    end
  end

  // FIFO next state: a full FIFO still accepts a word when a pop lands in the same clk.
  always_comb begin
    do_pop   = rd_en && (count_q != '0);
    do_push  = commit_q && ((count_q != FULL_COUNT) || do_pop);
    ovr_evt  = commit_q && (count_q == FULL_COUNT) && !do_pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    frame_err_d   = (frame_err_q   & ~err_clr) | frame_evt;
    parity_err_d  = (parity_err_q  & ~err_clr) | par_evt;
    overrun_err_d = (overrun_err_q & ~err_clr) | ovr_evt;
  end

  // FIFO storage, pointers and sticky error flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      frame_err_q   <= frame_err_d;
      parity_err_q  <= parity_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign rd_data     = mem_q[rd_ptr_q];
  assign rd_valid    = (count_q != '0);
  assign fifo_count  = count_q;
  assign busy        = (state_q != S_IDLE);
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: drives serial frames into uart_rx_fifo and compares its
// FIFO and flag outputs against a queue-based model of received words.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_HZ     = 3200000;
  localparam int BAUD       = 100000;
  localparam int OVERSAMPLE = 8;
  localparam int DATA_BITS  = 8;
  localparam int PARITY     = 2;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 8;
  localparam int BIT_CLKS   = CLK_HZ / BAUD;
  localparam int CW         = $clog2(FIFO_DEPTH + 1);
  // Clocks from a frame's start edge to the clk where its word is written:
  // 2.5 clks to reach START, then the mid-bit vote of bit 10 at tick 5 of 8.
  localparam int COMMIT_NEG = 347;

  logic                 clk, reset, rx, rd_en, err_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid, busy, frame_err, parity_err, overrun_err;
  logic [CW-1:0]        fifo_count;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   check_en = 0;

  logic [7:0] model_q[$];
  bit         exp_frame, exp_par, exp_ovr;

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE), .DATA_BITS(DATA_BITS),
    .PARITY(PARITY), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count), .busy(busy),
    .frame_err(frame_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Between frames the DUT must be idle and agree with the model on every cycle.
  always @(posedge clk) begin
    #1;
    if (check_en && reset) begin
      checkOutput("busy_idle", busy, 0);
      checkOutput("rd_valid", rd_valid, model_q.size() != 0);
      checkOutput("fifo_count", fifo_count, model_q.size());
      if (model_q.size() != 0) checkOutput("rd_data", rd_data, model_q[0]);
      checkOutput("frame_err", frame_err, exp_frame);
      checkOutput("parity_err", parity_err, exp_par);
      checkOutput("overrun_err", overrun_err, exp_ovr);
    end
  end

  // Sends one even-parity frame starting at the current negedge; stop_low>0
  // holds the stop bit low for that many bit times to force a break.
  task automatic applyStimulus(input logic [7:0] data, input bit bad_par,
                               input int stop_low, input bit record, input int gap);
    check_en = 0;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rx = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rx = (^data) ^ bad_par;
    repeat (BIT_CLKS) @(negedge clk);
    if (stop_low == 0) begin
      rx = 1'b1;
      repeat (BIT_CLKS * STOP_BITS) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (BIT_CLKS * stop_low) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS / 2) @(negedge clk);
      checkOutput("brk_holds", busy, 1);
      repeat (BIT_CLKS * 2) @(negedge clk);
    end
    if (record) begin
      if (bad_par) exp_par = 1;
      if (stop_low != 0) exp_frame = 1;
      if (!bad_par && stop_low == 0) begin
        if (model_q.size() == FIFO_DEPTH) exp_ovr = 1;
        else model_q.push_back(data);
      end
    end
    check_en = 1;
    repeat (gap) @(negedge clk);
  endtask

  // One-clk read pulse, called on a negedge.
  task automatic pop_word();
    rd_en = 1'b1;
    if (model_q.size() != 0) void'(model_q.pop_front());
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // One-clk error clear pulse, called on a negedge.
  task automatic clear_errors();
    err_clr   = 1'b1;
    exp_frame = 0;
    exp_par   = 0;
    exp_ovr   = 0;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  // Bounds the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios followed by a randomized stream of frames.
  initial begin
    reset = 1'b0; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_rd_valid", rd_valid, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_rd_data", rd_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_flags", {frame_err, parity_err, overrun_err}, 0);
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    check_en = 1;

    applyStimulus(8'h41, 0, 0, 1, 4);
    checkOutput("t1_data", rd_data, 8'h41);
    checkOutput("t1_count", fifo_count, 1);
    checkOutput("t1_valid", rd_valid, 1);
    pop_word();
    checkOutput("t1_pop_valid", rd_valid, 0);
    checkOutput("t1_pop_count", fifo_count, 0);

    check_en = 0;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_en = 1;
    checkOutput("glitch_busy", busy, 0);
    checkOutput("glitch_flags", {frame_err, parity_err, overrun_err}, 0);
    checkOutput("glitch_count", fifo_count, 0);

    applyStimulus(8'h33, 1, 0, 1, 4);
    checkOutput("par_err_set", parity_err, 1);
    checkOutput("par_count", fifo_count, 0);
    clear_errors();
    checkOutput("par_err_clr", parity_err, 0);
    applyStimulus(8'h33, 0, 0, 1, 4);
    checkOutput("par_ok_data", rd_data, 8'h33);
    pop_word();

    applyStimulus(8'h35, 0, 3, 1, 4);
    checkOutput("frm_err_set", frame_err, 1);
    checkOutput("frm_count", fifo_count, 0);
    applyStimulus(8'h36, 0, 0, 1, 4);
    checkOutput("frm_next_data", rd_data, 8'h36);
    pop_word();
    clear_errors();

    for (int i = 0; i < 9; i++) applyStimulus(8'h30 + 8'(i), 0, 0, 1, 4);
    checkOutput("ovr_count", fifo_count, 8);
    checkOutput("ovr_set", overrun_err, 1);
    for (int i = 0; i < 8; i++) begin
      checkOutput("ovr_order", rd_data, 8'h30 + 8'(i));
      pop_word();
    end
    checkOutput("ovr_drained", fifo_count, 0);
    clear_errors();

    for (int i = 0; i < 8; i++) applyStimulus(8'h30 + 8'(i), 0, 0, 1, 4);
    fork
      applyStimulus(8'h38, 0, 0, 1, 4);
      begin
        repeat (COMMIT_NEG) @(negedge clk);
        pop_word();
      end
    join
    checkOutput("simul_no_ovr", overrun_err, 0);
    checkOutput("simul_count", fifo_count, 8);
    checkOutput("simul_head", rd_data, 8'h31);
    for (int i = 0; i < 8; i++) pop_word();

    for (int n = 0; n < 25; n++) begin
      applyStimulus(8'($urandom), $urandom_range(0, 5) == 0,
                    ($urandom_range(0, 7) == 0) ? 1 : 0, 1, $urandom_range(4, 12));
      repeat ($urandom_range(0, 2)) pop_word();
      if ($urandom_range(0, 3) == 0) clear_errors();
    end
    while (model_q.size() != 0) pop_word();
    clear_errors();

    applyStimulus(8'h11, 0, 0, 1, 4);
    applyStimulus(8'h22, 0, 0, 1, 4);
    checkOutput("pre_rst_count", fifo_count, 2);
    fork
      applyStimulus(8'h5A, 0, 0, 0, 4);
      begin
        repeat (BIT_CLKS * 4) @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        exp_frame = 0; exp_par = 0; exp_ovr = 0;
        #1;
        checkOutput("mid_rst_count", fifo_count, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_valid", rd_valid, 0);
      end
    join
    reset = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    applyStimulus(8'h50, 0, 0, 1, 4);
    checkOutput("post_rst_data", rd_data, 8'h50);
    checkOutput("post_rst_count", fifo_count, 1);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
